// File: rtl/data_mem_responder.sv
// Data-memory responder: serves word reads/writes from a local array after a
// fixed number of wait states, signalling completion with Ready/Error pulses.
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [15:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Ready,
  output logic              Busy,
  output logic              Error
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                state;
  logic [3:0]            cnt;
  req_t                  req;
  req_t                  in_req;
  req_t                  cur;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  both, misalign, oor, fault, enter_done;

  assign in_req = '{rd: MemRead, wr: MemWrite, addr: Address, wdata: WriteData};

  // With zero wait states the commit edge is also the sampling edge, so the
  // access is decoded straight from the inputs while still in IDLE.
  assign cur = (state == IDLE) ? in_req : req;

  assign enter_done = ((state == IDLE) && (MemRead || MemWrite) && (WS == 4'd0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  assign idx      = cur.addr[DEPTH_LOG2:1];
  assign both     = cur.rd && cur.wr;
  assign misalign = cur.addr[0];
  assign oor      = |(cur.addr >> (DEPTH_LOG2 + 1));
  assign fault    = both || misalign || oor;

  assign Busy = (state != IDLE);

  // Array has no reset; Reset_n gating drops a commit that races a reset.
  always_ff @(posedge Clock) begin
    if (Reset_n && enter_done && cur.wr && !fault)
      mem[idx] <= cur.wdata;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      req      <= '0;
      ReadData <= '0;
      Ready    <= 1'b0;
      Error    <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      unique case (state)
        IDLE: if (MemRead || MemWrite) begin
          req   <= in_req;
          cnt   <= WS;
          state <= (WS == 4'd0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (enter_done) begin
        Ready <= 1'b1;
        Error <= fault;
        // Conflicting op or misalignment leave ReadData alone; an
        // out-of-range read returns zero.
        if (cur.rd && !cur.wr && !misalign) begin
          if (oor) ReadData <= '0;
          else     ReadData <= mem[idx];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with zero wait states,
// one with two, checked through an expected-result scoreboard queue.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mrd   [2];
  logic        mwr   [2];
  logic [15:0] maddr [2];
  logic [15:0] mwd   [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        bsy   [2];
  logic        err   [2];

  int tests = 0;
  int failed = 0;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(16), .DEPTH_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .Clock(clk), .Reset_n(rst_n), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .Address(maddr[0]), .WriteData(mwd[0]), .ReadData(rdata[0]),
    .Ready(rdy[0]), .Busy(bsy[0]), .Error(err[0])
  );

  data_mem_responder #(.DATA_W(16), .DEPTH_LOG2(8), .WAIT_STATES(2)) u_ws2 (
    .Clock(clk), .Reset_n(rst_n), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .Address(maddr[1]), .WriteData(mwd[1]), .ReadData(rdata[1]),
    .Ready(rdy[1]), .Busy(bsy[1]), .Error(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request after `gap` falling edges, hold it until Ready, then
  // compare against the scoreboard entry. chg perturbs inputs mid-wait.
  task automatic xact(input int s, input int gap, input bit r, input bit w,
                      input logic [15:0] a, input logic [15:0] d,
                      input bit ee, input logic [15:0] er, input int lat,
                      input bit chg, input string tag);
    exp_t e;
    int   nb;
    bit   got;
    repeat (gap) @(negedge clk);
    mrd[s] = r; mwr[s] = w; maddr[s] = a; mwd[s] = d;
    sb.push_back('{ee, er, lat});
    nb = 0;
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); #1;
      if (bsy[s]) nb++;
      if (chg && n == 1) begin
        maddr[s] = a + 16'h0010;
        mwd[s]   = ~d;
      end
      if (rdy[s]) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({tag, "_lat"},   n,        e.lat);
        chk({tag, "_err"},   err[s],   e.err);
        chk({tag, "_rdata"}, rdata[s], e.rdata);
        mrd[s] = 1'b0; mwr[s] = 1'b0;
      end
    end
    chk({tag, "_ready_seen"}, got, 1);
    if (!got) begin
      void'(sb.pop_front());
      mrd[s] = 1'b0; mwr[s] = 1'b0;
    end
    if (gap >= 2) chk({tag, "_busy_cycles"}, nb, lat);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mrd[i] = 1'b0; mwr[i] = 1'b0; maddr[i] = '0; mwd[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", rdy[i],   0);
      chk("rst_busy",  bsy[i],   0);
      chk("rst_error", err[i],   0);
      chk("rst_rdata", rdata[i], 0);
    end
    @(negedge clk) rst_n = 1'b1;

    // Two wait states
    xact(1, 2, 0, 1, 16'h0020, 16'h0000, 0, 16'h0000, 3, 0, "ws2_preload20");
    xact(1, 2, 0, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 3, 0, "ws2_wr10");
    xact(1, 2, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 3, 0, "ws2_rd10");
    xact(1, 2, 0, 1, 16'h0011, 16'hAAAA, 1, 16'hBEEF, 3, 0, "ws2_misal_wr");
    xact(1, 2, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 3, 0, "ws2_rd10_after_misal");
    xact(1, 2, 1, 1, 16'h0010, 16'h0F0F, 1, 16'hBEEF, 3, 0, "ws2_both");
    xact(1, 2, 1, 0, 16'h0010, 16'h0000, 0, 16'hBEEF, 3, 0, "ws2_rd10_after_both");
    xact(1, 2, 0, 1, 16'h0040, 16'h1111, 0, 16'hBEEF, 3, 0, "ws2_preload40");
    xact(1, 2, 0, 1, 16'h0030, 16'h7777, 0, 16'hBEEF, 3, 1, "ws2_wr30_chg");
    xact(1, 2, 1, 0, 16'h0030, 16'h0000, 0, 16'h7777, 3, 0, "ws2_rd30");
    xact(1, 2, 1, 0, 16'h0040, 16'h0000, 0, 16'h1111, 3, 0, "ws2_rd40");
    xact(1, 2, 1, 0, 16'h0013, 16'h0000, 1, 16'h1111, 3, 0, "ws2_misal_rd");

    // Reset while waiting aborts the write of 0xCAFE
    repeat (2) @(negedge clk);
    mwr[1] = 1'b1; maddr[1] = 16'h0020; mwd[1] = 16'hCAFE;
    @(posedge clk); #1;
    chk("abort_busy_before", bsy[1], 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_ready", rdy[1],   0);
    chk("abort_busy",  bsy[1],   0);
    chk("abort_error", err[1],   0);
    chk("abort_rdata", rdata[1], 0);
    mwr[1] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    xact(1, 2, 1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 3, 0, "ws2_rd20_after_abort");

    // Zero wait states, back-to-back
    xact(0, 2, 0, 1, 16'h0000, 16'h1234, 0, 16'h0000, 1, 0, "ws0_wr0");
    xact(0, 1, 1, 0, 16'h0000, 16'h0000, 0, 16'h1234, 2, 0, "ws0_rd0_b2b");
    xact(0, 2, 1, 0, 16'h0200, 16'h0000, 1, 16'h0000, 1, 0, "ws0_rd_oor");
    xact(0, 2, 1, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0, "ws0_rd0");
    xact(0, 2, 0, 1, 16'h0200, 16'h5555, 1, 16'h1234, 1, 0, "ws0_wr_oor");
    xact(0, 2, 1, 0, 16'h0000, 16'h0000, 0, 16'h1234, 1, 0, "ws0_rd0_after_oor");

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
